// File: rtl/haze_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : haze_pkg
// Purpose  : Shared types, widths and helper functions for the dehazing engine
// Revision : 1.0 - initial release
// ============================================================================
package haze_pkg;

  localparam int PIX_W   = 8;    // bits per colour channel
  localparam int ONE     = 256;  // 1.0 in the Q.8 fixed-point formats
  localparam int RECIP_W = 17;   // R[1] = 65536 needs 17 bits

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    S_ALE    = 2'd0,
    S_WAIT   = 2'd1,
    S_DEHAZE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Reciprocal table entry: round(65536/k); k=0 saturates to 65535.
  // Only ever called with constant arguments, so it folds at elaboration.
  function automatic logic [RECIP_W-1:0] recip(input int k);
    if (k == 0) return RECIP_W'(65535);
    return RECIP_W'((65536 + k / 2) / k);
  endfunction

  // Dark-channel value of a pixel: the smallest of its three channels.
  function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    logic [PIX_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/haze_removal_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : haze_removal_if
// Purpose  : AXI4-Stream pixel channel (32-bit TDATA, TVALID/TREADY/TLAST)
// Revision : 1.0 - initial release
// ============================================================================
interface haze_removal_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/haze_ale.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : haze_ale
// Purpose  : Atmospheric-light estimation: tracks the pixel with the brightest
//            dark channel over one frame (earliest wins on ties)
// Revision : 1.0 - initial release
// ============================================================================
module haze_ale
  import haze_pkg::*;
#(
  parameter int N = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,   // start a fresh estimate for the next frame
  input  logic   accept,  // one input pixel transferred this cycle
  input  pixel_t pix,
  output pixel_t a_pix,
  output logic   last,    // this transfer is pixel N of the frame
  output logic   done
);
  localparam int CNT_W = $clog2(N + 1);

  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] maxdark;
  logic [PIX_W-1:0] dark;

  assign dark = min3(pix.r, pix.g, pix.b);
  assign last = accept && (cnt == CNT_W'(N - 1));

  // Frame pixel counter, running maximum of the dark channel and the A capture
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt     <= '0;
      maxdark <= '0;
      a_pix   <= '0;
      done    <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
      // First pixel always seeds A so an all-black frame still yields a value
      if ((cnt == '0) || (dark > maxdark)) begin
        a_pix   <= pix;
        maxdark <= dark;
      end
      if (last) done <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/haze_removal_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : haze_removal_top
// Purpose  : Two-pass dark-channel-prior dehazer. Pass 1 estimates the
//            atmospheric light A, pass 2 streams the frame through
//            transmission estimation and scene recovery (5-stage pipeline).
// Revision : 1.0 - initial release
// ============================================================================
module haze_removal_top
  import haze_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int OMEGA      = 243,  // Q0.8
  parameter int T0         = 26    // Q1.8
) (
  input  logic           ACLK,
  input  logic           ARESET,
  input  logic           enable,
  haze_removal_if.slave  s_axis,
  haze_removal_if.master m_axis,
  output logic           o_intr
);
  localparam int N      = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int PROD_W = PIX_W + RECIP_W;        // I * R[A]
  localparam int OM_W   = 2 * PIX_W + 1;          // OMEGA * d
  localparam int MUL_W  = PIX_W + RECIP_W + 2;    // signed (I-A) * R[t]
  localparam int P_W    = MUL_W - PIX_W;          // after the >>> 8
  localparam int SUM_W  = P_W + 1;                // A + p
  localparam logic [PIX_W-1:0] OMEGA_Q = PIX_W'(OMEGA);
  localparam logic [PIX_W:0]   T0_Q    = (PIX_W + 1)'(T0);

  state_t state, state_nxt;
  pixel_t a_pix;
  logic   ALE_done, ale_accept, ale_last, ale_clear;
  logic   ce, s_ready, in_xfer, out_xfer, out_last;
  logic   [CNT_W-1:0] in_cnt, out_cnt;
  logic   v1, v2, v3, v4, v5;

  logic [2:0][PIX_W-1:0]  in_ch, a_ch, i1, i2, i3, j_nxt, j5;
  logic [2:0][PROD_W-1:0] prod1;
  logic [2:0][PIX_W:0]    ratio_nxt, ratio1;
  logic [PIX_W:0]         dmin, t_nxt, t2, t_clamped;
  logic [OM_W-1:0]        om;
  logic [RECIP_W-1:0]     rt_nxt, rt3;
  logic [2:0][P_W-1:0]    p_nxt, p4;
  logic signed [PIX_W:0]     diff4 [3];
  logic signed [MUL_W-1:0]   prod4 [3];
  logic signed [SUM_W-1:0]   sum5  [3];
  logic unused_in;

  // Reciprocal ROM: every entry is a constant-folded call, no divider is built
  logic [RECIP_W-1:0] recip_rom [0:ONE];
  for (genvar k = 0; k <= ONE; k++) begin : g_recip_rom
    assign recip_rom[k] = recip(k);
  end

  assign in_ch     = s_axis.tdata[23:0];
  assign a_ch      = a_pix;
  assign unused_in = ^{s_axis.tdata[31:24], s_axis.tlast};

  // Output is stalled only while a valid beat waits on downstream
  assign ce         = !(v5 && !m_axis.tready);
  assign out_xfer   = v5 && m_axis.tready;
  assign out_last   = out_xfer && (out_cnt == CNT_W'(N - 1));
  assign in_xfer    = (state == S_DEHAZE) && s_ready && s_axis.tvalid;
  assign ale_accept = (state == S_ALE) && s_axis.tvalid;
  assign ale_clear  = (state == S_DONE) && !enable;

  haze_ale #(.N(N)) u_ale (
    .clk    (ACLK),
    .rst    (ARESET),
    .clear  (ale_clear),
    .accept (ale_accept),
    .pix    (pixel_t'(s_axis.tdata[23:0])),
    .a_pix  (a_pix),
    .last   (ale_last),
    .done   (ALE_done)
  );

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_ALE;
    else        state <= state_nxt;
  end

  // Next state and input-side ready
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      S_ALE: begin
        s_ready = 1'b1;
        if (ale_last) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (enable) state_nxt = S_DEHAZE;
      end
      S_DEHAZE: begin
        s_ready = ce && (in_cnt != CNT_W'(N));
        if (out_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!enable) state_nxt = S_ALE;
      end
      default: state_nxt = S_ALE;
    endcase
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = {8'h00, j5};
  assign m_axis.tvalid = v5;
  assign m_axis.tlast  = v5 && (out_cnt == CNT_W'(N - 1));

  // Pass-2 input and output beat counters, cleared for the next frame
  always_ff @(posedge ACLK) begin
    if (ARESET || ale_clear) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_xfer)  in_cnt  <= in_cnt + CNT_W'(1);
      if (out_xfer) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // Frame-done pulse on the cycle after the TLAST beat leaves
  always_ff @(posedge ACLK) begin
    if (ARESET) o_intr <= 1'b0;
    else        o_intr <= out_last;
  end

  // Datapath arithmetic for each stage, feeding the stage registers below
  always_comb begin
    // S1: per-channel normalised intensity I/A, saturated at 1.0
    for (int c = 0; c < 3; c++) begin
      prod1[c]     = PROD_W'(in_ch[c]) * PROD_W'(recip_rom[a_ch[c]]);
      ratio_nxt[c] = (prod1[c] >= PROD_W'(ONE << 8)) ? (PIX_W + 1)'(ONE)
                                                     : (PIX_W + 1)'(prod1[c] >> 8);
    end
    // S2: dark channel of the ratios and raw transmission 1 - omega*d
    dmin = ratio1[0];
    if (ratio1[1] < dmin) dmin = ratio1[1];
    if (ratio1[2] < dmin) dmin = ratio1[2];
    om    = OM_W'(dmin) * OM_W'(OMEGA_Q);
    t_nxt = (PIX_W + 1)'(ONE) - (PIX_W + 1)'(om >> 8);
    // S3: floor the transmission at T0 and fetch 1/t
    t_clamped = (t2 < T0_Q) ? T0_Q : t2;
    rt_nxt    = recip_rom[t_clamped];
    // S4: (I - A) / t with a floor shift; S5: add A back and clamp to 8 bits
    for (int c = 0; c < 3; c++) begin
      diff4[c] = $signed({1'b0, i3[c]}) - $signed({1'b0, a_ch[c]});
      prod4[c] = MUL_W'(diff4[c]) * $signed({{(MUL_W - RECIP_W){1'b0}}, rt3});
      p_nxt[c] = P_W'(prod4[c] >>> 8);
      sum5[c]  = $signed({{(SUM_W - PIX_W){1'b0}}, a_ch[c]}) + SUM_W'($signed(p4[c]));
      if (sum5[c] < 0)                 j_nxt[c] = '0;
      else if (sum5[c] > SUM_W'(255))  j_nxt[c] = 8'hFF;
      else                             j_nxt[c] = PIX_W'(sum5[c]);
    end
  end

  // Pipeline stage registers; the whole pipe holds while ce is low
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      {v1, v2, v3, v4, v5} <= '0;
      i1 <= '0; i2 <= '0; i3 <= '0;
      ratio1 <= '0; t2 <= '0; rt3 <= '0; p4 <= '0; j5 <= '0;
    end else if (ce) begin
      v1 <= in_xfer;  i1 <= in_ch;  ratio1 <= ratio_nxt;
      v2 <= v1;       i2 <= i1;     t2     <= t_nxt;
      v3 <= v2;       i3 <= i2;     rt3    <= rt_nxt;
      v4 <= v3;       p4 <= p_nxt;
      v5 <= v4;       j5 <= j_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_haze_removal_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_haze_removal_top
// Purpose  : Self-checking bench for haze_removal_top on a 4x4 frame
// Revision : 1.0 - initial release
// ============================================================================
module tb_haze_removal_top;
  import haze_pkg::*;

  localparam int W = 4, H = 4, N = W * H;
  localparam int OMEGA = 243, T0 = 26;

  logic ACLK = 1'b0;
  logic ARESET, enable, o_intr;
  int   errors = 0, checks = 0;

  logic [23:0] frame  [N];   // pass-1 pixels
  logic [23:0] dframe [N];   // pass-2 pixels
  logic [23:0] got    [N];   // pass-2 outputs as seen
  logic [23:0] aexp;

  haze_removal_if s_if ();
  haze_removal_if m_if ();

  haze_removal_top #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .OMEGA(OMEGA), .T0(T0)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .enable (enable),
    .s_axis (s_if),
    .m_axis (m_if),
    .o_intr (o_intr)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int dark_of(input logic [23:0] p);
    int m;
    m = int'(p[7:0]);
    if (int'(p[15:8]) < m)  m = int'(p[15:8]);
    if (int'(p[23:16]) < m) m = int'(p[23:16]);
    return m;
  endfunction

  // A is the earliest pixel whose dark channel equals the frame maximum
  function automatic logic [23:0] ale_model();
    int best;
    best = -1;
    for (int i = 0; i < N; i++) if (dark_of(frame[i]) > best) best = dark_of(frame[i]);
    for (int i = 0; i < N; i++) if (dark_of(frame[i]) == best) return frame[i];
    return '0;
  endfunction

  function automatic int recip_ref(input int k);
    if (k == 0) return 65535;
    return int'($floor(65536.0 / k + 0.5));
  endfunction

  function automatic logic [23:0] dehaze_ref(input logic [23:0] a, input logic [23:0] px);
    int ia [3], aa [3], ratio [3];
    int d, t, rt, j;
    logic [23:0] res;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      ia[c] = int'(px[8*c +: 8]);
      aa[c] = int'(a[8*c +: 8]);
      ratio[c] = (ia[c] * recip_ref(aa[c])) / 256;
      if (ratio[c] > 256) ratio[c] = 256;
    end
    d = ratio[0];
    if (ratio[1] < d) d = ratio[1];
    if (ratio[2] < d) d = ratio[2];
    t = 256 - (OMEGA * d) / 256;
    if (t < T0) t = T0;
    rt = recip_ref(t);
    for (int c = 0; c < 3; c++) begin
      j = aa[c] + int'($floor(real'((ia[c] - aa[c]) * rt) / 256.0));
      if (j < 0)   j = 0;
      if (j > 255) j = 255;
      res[8*c +: 8] = 8'(j);
    end
    return res;
  endfunction

  function automatic logic [23:0] rand_pix(input int bmax);
    return {8'($urandom), 8'($urandom), 8'($urandom_range(bmax, 0))};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    ARESET = 1'b1; enable = 1'b0; s_if.tvalid = 1'b0; s_if.tdata = '0;
    s_if.tlast = 1'b0; m_if.tready = 1'b1;
    tick(); tick();
    ARESET = 1'b0;
  endtask

  task automatic send_ale();
    for (int i = 0; i < N; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = {8'($urandom), frame[i]};
      #1;
      check("ale_tready", s_if.tready, 1);
      check("ale_done_early", dut.ALE_done, 0);
      @(posedge ACLK); #1;
    end
    s_if.tvalid = 1'b0;
    check("ale_done", dut.ALE_done, 1);
    check("ale_state_wait", 32'(dut.state), 32'(S_WAIT));
    check("wait_tready", s_if.tready, 0);
  endtask

  task automatic run_dehaze(input int stall_at);
    int in_i, out_i, cyc, first_in, stall_left;
    logic prev_stall, prev_lastx;
    logic [31:0] prev_data;
    in_i = 0; out_i = 0; cyc = 0; first_in = 0; stall_left = 3;
    prev_stall = 1'b0; prev_lastx = 1'b0; prev_data = '0;
    enable = 1'b1;
    while (out_i < N && cyc < 200) begin
      m_if.tready = !(out_i >= stall_at && stall_left > 0);
      if (!m_if.tready) stall_left--;
      s_if.tvalid = 1'b1;
      s_if.tdata  = {8'($urandom), dframe[(in_i < N) ? in_i : N - 1]};
      #1;
      if (prev_stall) begin
        check("hold_valid", m_if.tvalid, 1);
        check("hold_data", m_if.tdata, prev_data);
      end
      if (m_if.tvalid && !m_if.tready) check("stall_s_tready", s_if.tready, 0);
      check("intr_timing", o_intr, prev_lastx);
      prev_lastx = 1'b0;
      if (m_if.tvalid && m_if.tready) begin
        got[out_i] = m_if.tdata[23:0];
        check("out_pixel", m_if.tdata, {8'h00, dehaze_ref(aexp, dframe[out_i])});
        check("tlast", m_if.tlast, out_i == N - 1);
        if (out_i == 0) check("latency", cyc - first_in, 5);
        prev_lastx = (out_i == N - 1);
        out_i++;
      end
      if (s_if.tvalid && s_if.tready) begin
        if (in_i == 0) first_in = cyc;
        in_i++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      tick();
      cyc++;
    end
    check("out_count", out_i, N);
    check("in_count", in_i, N);
    check("intr_pulse", o_intr, 1);
    check("done_state", 32'(dut.state), 32'(S_DONE));
    check("done_s_tready", s_if.tready, 0);
    check("done_m_tvalid", m_if.tvalid, 0);
    s_if.tvalid = 1'b0; m_if.tready = 1'b1;
    tick();
    check("intr_single", o_intr, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    #1;
    check("rst_s_tready", s_if.tready, 1);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_tlast", m_if.tlast, 0);
    check("rst_intr", o_intr, 0);
    check("rst_ale_done", dut.ALE_done, 0);
    check("rst_state", 32'(dut.state), 32'(S_ALE));
    check("rst_a", dut.a_pix, 0);

    // ALE: one bright pixel among greys
    for (int i = 0; i < N; i++) frame[i] = 24'h646464;
    frame[7] = 24'hFAF0E6;
    send_ale();
    check("ale_a_bright", dut.a_pix, 24'hFAF0E6);
    check("ale_a_model", dut.a_pix, ale_model());
    s_if.tvalid = 1'b1;  // extra input must be refused while waiting
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wait_refuse", s_if.tready, 0);
      check("wait_no_tvalid", m_if.tvalid, 0);
      tick();
    end
    check("wait_a_frozen", dut.a_pix, 24'hFAF0E6);

    // ALE tie-break: earliest of two equal dark channels wins
    do_reset();
    for (int i = 0; i < N; i++) frame[i] = rand_pix(179);
    frame[2] = 24'hC8BEB4;
    frame[9] = 24'hB4DCBE;
    send_ale();
    check("ale_tie", dut.a_pix, 24'hC8BEB4);
    check("ale_tie_model", dut.a_pix, ale_model());

    // Dehaze with A = (200,200,200), directed pixels first, then random
    do_reset();
    for (int i = 0; i < N; i++) frame[i] = rand_pix(199);
    frame[0] = 24'hC8C8C8;
    send_ale();
    check("ale_a200", dut.a_pix, 24'hC8C8C8);
    aexp = ale_model();
    dframe[0] = 24'h646464; dframe[1] = 24'h000000;
    dframe[2] = 24'hC8C8C8; dframe[3] = 24'hD2D2D2;
    for (int i = 4; i < N; i++) dframe[i] = 24'($urandom);
    run_dehaze(4);
    check("j_100", got[0], 24'h0A0A0A);
    check("j_zero", got[1], 24'h000000);
    check("j_eq_a", got[2], 24'hC8C8C8);
    check("j_t0_clamp", got[3], 24'hFFFFFF);

    // Back to ALE and a second, fully random frame
    enable = 1'b0;
    tick();
    check("rearm_state", 32'(dut.state), 32'(S_ALE));
    check("rearm_a", dut.a_pix, 0);
    check("rearm_ale_done", dut.ALE_done, 0);
    check("rearm_s_tready", s_if.tready, 1);
    for (int i = 0; i < N; i++) frame[i] = rand_pix(255);
    send_ale();
    aexp = ale_model();
    check("ale2_a_model", dut.a_pix, aexp);
    for (int i = 0; i < N; i++) dframe[i] = 24'($urandom);
    run_dehaze(9);
    enable = 1'b0;
    tick();

    // Reset in the middle of pass 2
    for (int i = 0; i < N; i++) frame[i] = rand_pix(255);
    send_ale();
    enable = 1'b1;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_if.tdata = {8'h00, 24'($urandom)};
      tick();
    end
    ARESET = 1'b1;
    tick();
    check("mid_rst_m_tvalid", m_if.tvalid, 0);
    check("mid_rst_m_tdata", m_if.tdata, 0);
    check("mid_rst_tlast", m_if.tlast, 0);
    check("mid_rst_intr", o_intr, 0);
    check("mid_rst_ale_done", dut.ALE_done, 0);
    check("mid_rst_s_tready", s_if.tready, 1);
    check("mid_rst_state", 32'(dut.state), 32'(S_ALE));
    ARESET = 1'b0;
    s_if.tvalid = 1'b0;
    enable = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
